// File: rtl/pong_game_ctrl_if.sv
// pong_game_ctrl_if
// Groups the pong game controller's event inputs and status outputs into one
// bundle. Clock and reset stay outside the bundle as plain ports.
//   master : drives btn, pause_btn, frame_tick, hit, miss; observes the status
//   slave  : the controller; observes events, drives gra_still, state,
//            balls_left, score, hiscore, level, new_record
// Parameter values must match the ones given to pong_game_ctrl.
interface pong_game_ctrl_if #(
  parameter int LIVES_W      = 2,
  parameter int SCORE_DIGITS = 2,
  parameter int LEVEL_W      = 3,
  parameter int N_BTN        = 2
);
  logic [N_BTN-1:0]          btn;
  logic                      pause_btn;
  logic                      frame_tick;
  logic                      hit;
  logic                      miss;
  logic                      gra_still;
  logic [2:0]                state;
  logic [LIVES_W-1:0]        balls_left;
  logic [4*SCORE_DIGITS-1:0] score;
  logic [4*SCORE_DIGITS-1:0] hiscore;
  logic [LEVEL_W-1:0]        level;
  logic                      new_record;

  modport master (
    output btn, pause_btn, frame_tick, hit, miss,
    input  gra_still, state, balls_left, score, hiscore, level, new_record
  );

  modport slave (
    input  btn, pause_btn, frame_tick, hit, miss,
    output gra_still, state, balls_left, score, hiscore, level, new_record
  );
endinterface

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl
// Game-control FSMD for the pong family: sequences new-game, play, new-ball,
// pause and game-over phases; keeps a BCD score, a high score kept since
// reset, the remaining ball count, a speed level and a frame-based delay timer.
// Ports:
//   clk   : rising-edge system clock
//   reset : asynchronous, active-low reset
//   bus   : pong_game_ctrl_if.slave
//           in : btn, pause_btn (debounced levels), frame_tick, hit, miss (pulses)
//           out: gra_still (decoded from state), state, balls_left, score,
//                hiscore, level, new_record (all registered)
module pong_game_ctrl #(
  parameter int LIVES        = 3,
  parameter int LIVES_W      = 2,
  parameter int SCORE_DIGITS = 2,
  parameter int TIMER_FRAMES = 120,
  parameter int LEVEL_W      = 3,
  parameter int LEVEL_MAX    = 7,
  parameter int N_BTN        = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  pong_game_ctrl_if.slave        bus
);

  localparam int SCORE_W = 4 * SCORE_DIGITS;
  localparam int TIMER_W = $clog2(TIMER_FRAMES + 1);

  localparam logic [SCORE_W-1:0] SCORE_MAX   = {SCORE_DIGITS{4'h9}};
  localparam logic [TIMER_W-1:0] TIMER_LOAD  = TIMER_W'(TIMER_FRAMES);
  localparam logic [TIMER_W-1:0] TIMER_ZERO  = {TIMER_W{1'b0}};
  localparam logic [LEVEL_W-1:0] LEVEL_TOP   = LEVEL_W'(LEVEL_MAX);
  localparam logic [LEVEL_W-1:0] LEVEL_ZERO  = {LEVEL_W{1'b0}};
  localparam logic [LIVES_W-1:0] BALLS_FULL  = LIVES_W'(LIVES);
  localparam logic [LIVES_W-1:0] BALLS_FIRST = LIVES_W'(LIVES - 1);
  localparam logic [LIVES_W-1:0] BALLS_ZERO  = {LIVES_W{1'b0}};
  localparam logic [SCORE_W-1:0] SCORE_ZERO  = {SCORE_W{1'b0}};

  typedef enum logic [2:0] {
    ST_NEWGAME = 3'd0,
    ST_PLAY    = 3'd1,
    ST_NEWBALL = 3'd2,
    ST_PAUSE   = 3'd3,
    ST_OVER    = 3'd4
  } state_t;

  // BCD increment by one with ripple carry across digits.
  function automatic logic [SCORE_W-1:0] bcd_inc(input logic [SCORE_W-1:0] v);
    logic [SCORE_W-1:0] r;
    logic               c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < SCORE_DIGITS; i++) begin
      if (c) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c           = 1'b0;
        end
      end else begin
        r[4*i +: 4] = v[4*i +: 4];
      end
    end
    return r;
  endfunction

  state_t             state_r;
  logic [N_BTN-1:0]   btn_d_r;
  logic               pause_d_r;
  logic [TIMER_W-1:0] timer_r;
  logic [LIVES_W-1:0] balls_r;
  logic [SCORE_W-1:0] score_r;
  logic [SCORE_W-1:0] hiscore_r;
  logic [LEVEL_W-1:0] level_r;
  logic               new_record_r;
  logic               over_entry_r;

  logic               press_s;
  logic               pstart_s;
  logic               timer_up_s;
  logic               score_sat_s;

  // Rising-edge detectors; delayed copies reset to ones so a button held
  // through reset is not seen as a press.
  assign press_s     = |(bus.btn & ~btn_d_r);
  assign pstart_s    = bus.pause_btn & ~pause_d_r;
  assign timer_up_s  = (timer_r == TIMER_ZERO);
  assign score_sat_s = (score_r == SCORE_MAX);

  // Game FSM with datapath registers (score, level, balls, timer, hiscore).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_NEWGAME;
      btn_d_r      <= {N_BTN{1'b1}};
      pause_d_r    <= 1'b1;
      timer_r      <= TIMER_ZERO;
      balls_r      <= BALLS_FULL;
      score_r      <= SCORE_ZERO;
      hiscore_r    <= SCORE_ZERO;
      level_r      <= LEVEL_ZERO;
      new_record_r <= 1'b0;
      over_entry_r <= 1'b0;
    end else begin
      btn_d_r      <= bus.btn;
      pause_d_r    <= bus.pause_btn;
      new_record_r <= 1'b0;

      // Frame countdown; frozen while paused. A start below overrides it.
      if (bus.frame_tick && !timer_up_s && (state_r != ST_PAUSE)) begin
        timer_r <= timer_r - TIMER_W'(1);
      end else begin
        timer_r <= timer_r;
      end

      case (state_r)
        ST_NEWGAME: begin
          score_r <= SCORE_ZERO;
          level_r <= LEVEL_ZERO;
          if (press_s) begin
            state_r <= ST_PLAY;
            balls_r <= BALLS_FIRST;
          end else begin
            balls_r <= BALLS_FULL;
          end
        end

        ST_PLAY: begin
          // hit beats miss; either beats a coincident pause press.
          if (bus.hit) begin
            if (!score_sat_s) begin
              score_r <= bcd_inc(score_r);
              // Digit 0 wrapping 9->0 bumps the speed level.
              if ((score_r[3:0] == 4'd9) && (level_r != LEVEL_TOP)) begin
                level_r <= level_r + LEVEL_W'(1);
              end
            end
          end else if (bus.miss) begin
            timer_r <= TIMER_LOAD;
            if (balls_r == BALLS_ZERO) begin
              state_r      <= ST_OVER;
              over_entry_r <= 1'b1;
            end else begin
              state_r <= ST_NEWBALL;
              balls_r <= balls_r - LIVES_W'(1);
            end
          end else if (pstart_s) begin
            state_r <= ST_PAUSE;
          end
        end

        ST_PAUSE: begin
          if (pstart_s) begin
            state_r <= ST_PLAY;
          end
        end

        ST_NEWBALL: begin
          // Needs a fresh edge once the delay has run out.
          if (timer_up_s && press_s) begin
            state_r <= ST_PLAY;
          end
        end

        ST_OVER: begin
          over_entry_r <= 1'b0;
          // Packed BCD orders the same as the decimal value.
          if (over_entry_r && (score_r > hiscore_r)) begin
            hiscore_r    <= score_r;
            new_record_r <= 1'b1;
          end
          if (timer_up_s) begin
            state_r <= ST_NEWGAME;
          end
        end

        default: begin
          state_r <= ST_NEWGAME;
        end
      endcase
    end
  end

  assign bus.gra_still  = (state_r != ST_PLAY);
  assign bus.state      = state_r;
  assign bus.balls_left = balls_r;
  assign bus.score      = score_r;
  assign bus.hiscore    = hiscore_r;
  assign bus.level      = level_r;
  assign bus.new_record = new_record_r;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb_pong_game_ctrl
// Self-checking bench for pong_game_ctrl (TIMER_FRAMES = 4, other parameters
// at their defaults). An integer-level reference model (score as a plain
// number, level derived as score/10) tracks every cycle; directed steps follow
// the game flow and a randomized phase closes the run.
module tb_pong_game_ctrl;

  localparam int LIVES        = 3;
  localparam int LIVES_W      = 2;
  localparam int SCORE_DIGITS = 2;
  localparam int TIMER_FRAMES = 4;
  localparam int LEVEL_W      = 3;
  localparam int LEVEL_MAX    = 7;
  localparam int N_BTN        = 2;
  localparam int SCORE_TOP    = 99;

  logic clk;
  logic reset;

  pong_game_ctrl_if #(
    .LIVES_W(LIVES_W), .SCORE_DIGITS(SCORE_DIGITS),
    .LEVEL_W(LEVEL_W), .N_BTN(N_BTN)
  ) bus ();

  pong_game_ctrl #(
    .LIVES(LIVES), .LIVES_W(LIVES_W), .SCORE_DIGITS(SCORE_DIGITS),
    .TIMER_FRAMES(TIMER_FRAMES), .LEVEL_W(LEVEL_W), .LEVEL_MAX(LEVEL_MAX),
    .N_BTN(N_BTN)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: 0 new game, 1 play, 2 new ball, 3 pause, 4 over.
  int               m_state;
  int               m_score;
  int               m_hi;
  int               m_balls;
  int               m_timer;
  bit               m_newrec;
  bit               m_over_first;
  logic [N_BTN-1:0] m_btn_prev;
  logic             m_pause_prev;

  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] r;
    int          x;
    r = '0;
    x = v;
    for (int i = 0; i < SCORE_DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int m_level();
    return (m_score / 10 > LEVEL_MAX) ? LEVEL_MAX : m_score / 10;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state      = 0;
    m_score      = 0;
    m_hi         = 0;
    m_balls      = LIVES;
    m_timer      = 0;
    m_newrec     = 1'b0;
    m_over_first = 1'b0;
    m_btn_prev   = '1;
    m_pause_prev = 1'b1;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    bit press, pst, tup;
    int n_timer;
    press        = |(bus.btn & ~m_btn_prev);
    pst          = bus.pause_btn & ~m_pause_prev;
    m_btn_prev   = bus.btn;
    m_pause_prev = bus.pause_btn;
    tup          = (m_timer == 0);
    m_newrec     = 1'b0;
    n_timer      = (bus.frame_tick && m_timer > 0 && m_state != 3) ? m_timer - 1 : m_timer;
    case (m_state)
      0: begin
        m_score = 0;
        m_balls = press ? LIVES - 1 : LIVES;
        if (press) m_state = 1;
      end
      1: begin
        if (bus.hit) begin
          if (m_score < SCORE_TOP) m_score = m_score + 1;
        end else if (bus.miss) begin
          n_timer = TIMER_FRAMES;
          if (m_balls == 0) begin
            m_state      = 4;
            m_over_first = 1'b1;
          end else begin
            m_state = 2;
            m_balls = m_balls - 1;
          end
        end else if (pst) begin
          m_state = 3;
        end
      end
      2: if (tup && press) m_state = 1;
      3: if (pst) m_state = 1;
      4: begin
        if (m_over_first) begin
          m_over_first = 1'b0;
          if (m_score > m_hi) begin
            m_hi     = m_score;
            m_newrec = 1'b1;
          end
        end
        if (tup) m_state = 0;
      end
      default: m_state = 0;
    endcase
    m_timer = n_timer;
  endtask

  task automatic check_outputs();
    check("state",      32'(bus.state),      32'(m_state));
    check("gra_still",  32'(bus.gra_still),  32'(m_state != 1));
    check("balls_left", 32'(bus.balls_left), 32'(m_balls));
    check("score",      32'(bus.score),      to_bcd(m_score));
    check("hiscore",    32'(bus.hiscore),    to_bcd(m_hi));
    check("level",      32'(bus.level),      32'(m_level()));
    check("new_record", 32'(bus.new_record), 32'(m_newrec));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"},   32'(bus.state),      32'd0);
    check({tag, "_gra"},     32'(bus.gra_still),  32'd1);
    check({tag, "_balls"},   32'(bus.balls_left), 32'd3);
    check({tag, "_score"},   32'(bus.score),      32'h0);
    check({tag, "_hiscore"}, 32'(bus.hiscore),    32'h0);
    check({tag, "_level"},   32'(bus.level),      32'd0);
    check({tag, "_newrec"},  32'(bus.new_record), 32'd0);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic press_btn();
    bus.btn = 2'b01;
    tick();
    bus.btn = 2'b00;
    tick();
  endtask

  task automatic hit_pulse();
    bus.hit = 1'b1;
    tick();
    bus.hit = 1'b0;
    tick();
  endtask

  task automatic frame_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      bus.frame_tick = 1'b1;
      tick();
      bus.frame_tick = 1'b0;
      tick();
    end
  endtask

  // Miss in PLAY, check early press is ignored, then resume after the delay.
  task automatic lose_ball(input int exp_balls);
    bus.miss = 1'b1;
    tick();
    bus.miss = 1'b0;
    check("nb_state", 32'(bus.state), 32'd2);
    check("nb_balls", 32'(bus.balls_left), 32'(exp_balls));
    frame_pulses(2);
    press_btn();
    check("nb_early_press", 32'(bus.state), 32'd2);
    frame_pulses(2);
    bus.btn = 2'b01;
    tick();
    bus.btn = 2'b00;
    check("nb_resume", 32'(bus.state), 32'd1);
    tick();
  endtask

  initial begin
    int nhits;
    reset          = 1'b0;
    bus.btn        = 2'b01;
    bus.pause_btn  = 1'b0;
    bus.frame_tick = 1'b0;
    bus.hit        = 1'b0;
    bus.miss       = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("rst");

    // Button held through reset must not start a game.
    reset = 1'b1;
    repeat (3) tick();
    check("held_state", 32'(bus.state), 32'd0);
    check("held_balls", 32'(bus.balls_left), 32'd3);
    bus.btn = 2'b00;
    tick();
    bus.btn = 2'b01;
    tick();
    bus.btn = 2'b00;
    check("start_state", 32'(bus.state), 32'd1);
    check("start_balls", 32'(bus.balls_left), 32'd2);
    check("start_gra",   32'(bus.gra_still), 32'd0);

    repeat (12) hit_pulse();
    check("score12", 32'(bus.score), 32'h12);
    check("level1",  32'(bus.level), 32'd1);

    // hit wins over coincident miss.
    bus.hit  = 1'b1;
    bus.miss = 1'b1;
    tick();
    bus.hit  = 1'b0;
    bus.miss = 1'b0;
    check("hm_score", 32'(bus.score), 32'h13);
    check("hm_state", 32'(bus.state), 32'd1);
    check("hm_balls", 32'(bus.balls_left), 32'd2);

    // Pause: events ignored, second edge resumes.
    bus.pause_btn = 1'b1;
    tick();
    check("pause_state", 32'(bus.state), 32'd3);
    check("pause_gra",   32'(bus.gra_still), 32'd1);
    bus.hit = 1'b1;
    tick();
    bus.hit  = 1'b0;
    bus.miss = 1'b1;
    tick();
    bus.miss = 1'b0;
    check("pause_score", 32'(bus.score), 32'h13);
    check("pause_balls", 32'(bus.balls_left), 32'd2);
    bus.pause_btn = 1'b0;
    tick();
    bus.pause_btn = 1'b1;
    tick();
    check("resume_state", 32'(bus.state), 32'd1);
    bus.pause_btn = 1'b0;
    tick();

    // Drive the score into saturation.
    for (int i = 0; i < 93; i++) begin
      bus.hit = 1'b1;
      tick();
      bus.hit = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
    end
    check("score_sat", 32'(bus.score), 32'h99);
    check("level_sat", 32'(bus.level), 32'd7);

    lose_ball(1);
    lose_ball(0);
    bus.miss = 1'b1;
    tick();
    bus.miss = 1'b0;
    check("over_state", 32'(bus.state), 32'd4);
    tick();
    check("rec_pulse", 32'(bus.new_record), 32'd1);
    check("rec_hi",    32'(bus.hiscore), 32'h99);
    tick();
    check("rec_end", 32'(bus.new_record), 32'd0);
    frame_pulses(4);
    check("over_done", 32'(bus.state), 32'd0);

    // Second game with a lower score: no new record.
    press_btn();
    nhits = $urandom_range(1, 30);
    repeat (nhits) hit_pulse();
    lose_ball(1);
    lose_ball(0);
    bus.miss = 1'b1;
    tick();
    bus.miss = 1'b0;
    tick();
    check("g2_no_rec", 32'(bus.new_record), 32'd0);
    check("g2_hi",     32'(bus.hiscore), 32'h99);
    frame_pulses(4);

    // Third game, reset in the middle of play.
    press_btn();
    repeat ($urandom_range(1, 8)) hit_pulse();
    reset = 1'b0;
    #2;
    check_reset_values("midrst");
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick();

    // Randomized play against the model.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) bus.btn = N_BTN'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) bus.pause_btn = ~bus.pause_btn;
      bus.frame_tick = ($urandom_range(0, 2) == 0);
      bus.hit        = ($urandom_range(0, 3) == 0);
      bus.miss       = ($urandom_range(0, 31) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pong_game_ctrl.md
# pong_game_ctrl

Parametrised game-control FSMD for the pong family. Sequences new-game, play, new-ball, pause and game-over phases, and keeps an N-digit BCD score, a persistent high score, a ball/lives count, a speed level and a frame-based delay timer. Sits between the graph unit (hit/miss in, gra_still out), the text unit (score, high score, balls and level out) and the top-level rgb multiplexer (state out).

## Interface
- LIVES, 3: balls per game, 1..2^LIVES_W-1.
- LIVES_W, 2: width of balls_left.
- SCORE_DIGITS, 2: BCD digits in score and hiscore, ≥1.
- TIMER_FRAMES, 120: delay length in frame ticks (2 s at 60 Hz), ≥1.
- LEVEL_W, 3: width of level.
- LEVEL_MAX, 7: level saturation value, ≤2^LEVEL_W-1.
- N_BTN, 2: play-button count.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- btn  in  N_BTN  play buttons, debounced, level.
- pause_btn  in  1  pause toggle, debounced, level.
- frame_tick  in  1  one-cycle pulse per frame (pixel 0,0).
- hit  in  1  one-cycle pulse: ball returned by paddle.
- miss  in  1  one-cycle pulse: ball lost.
- gra_still  out  1  1 = freeze graph animation.
- state  out  3  0 NEWGAME, 1 PLAY, 2 NEWBALL, 3 PAUSE, 4 OVER.
- balls_left  out  LIVES_W  balls remaining after the current one.
- score  out  4*SCORE_DIGITS  BCD, digit 0 in [3:0].
- hiscore  out  4*SCORE_DIGITS  BCD best score since reset.
- level  out  LEVEL_W  speed level for the graph unit.
- new_record  out  1  one-cycle pulse when hiscore is updated.

## Operation
- Edge detect: press = |(btn & ~btn_d); pstart = pause_btn & ~pause_d. btn_d and pause_d reset to all ones, so a button held through reset does not count as a press.
- gra_still = 0 only in PLAY. It is decoded from state_reg.
- NEWGAME: score ← 0, level ← 0, balls_left ← LIVES. On press: go to PLAY and set balls_left ← LIVES-1.
- PLAY:
  - hit has priority over miss when both arrive in the same cycle; the miss is dropped.
  - hit: score +1 in BCD with per-digit carry. Score saturates at all 9s and does not wrap.
  - Level: +1 when digit 0 wraps 9→0. Level saturates at LEVEL_MAX. It is not incremented while score is saturated.
  - miss with balls_left==0: go to OVER and start the timer.
  - miss otherwise: go to NEWBALL, balls_left −1, start the timer.
  - pstart with no hit/miss in the same cycle: go to PAUSE. If hit/miss coincides, the hit/miss takes effect and the pause press is ignored.
- PAUSE: hit and miss are ignored. pstart returns to PLAY. Score, level, balls_left and the timer are held.
- NEWBALL: go to PLAY when timer_up and press are both true in the same cycle. A press before timer_up is discarded; a fresh press edge is required after timer_up.
- OVER, on the entry cycle: if score > hiscore (unsigned compare of the packed BCD), hiscore ← score and new_record pulses for 1 cycle. Go to NEWGAME on timer_up.
- Timer: start loads the count with TIMER_FRAMES. Each frame_tick decrements the count while it is nonzero. timer_up = (count==0). The count resets to 0, so timer_up is 1 out of reset. Start has priority over a coincident frame_tick.
- Undefined state encodings (5–7) go to NEWGAME on the next clock.

## Timing
- Reset values (asserted asynchronously): state 0, gra_still 1, balls_left LIVES, score 0, hiscore 0, level 0, new_record 0, timer count 0.
- All outputs are registered except gra_still, which is decoded from state_reg.
- Latencies, from the input's sampling edge:
  - hit → score/level update: 1 cycle.
  - miss → state/balls_left change: 1 cycle.
  - Press → PLAY: 1 cycle.
  - OVER entry → hiscore update and new_record: 1 cycle after entry.
- Delay: timer_up rises on the TIMER_FRAMES-th frame_tick after start.
- Reset mid-game returns to NEWGAME immediately and also clears hiscore.

## Test plan
- Reset with btn=2'b01 held: state stays 0 and balls_left=3. Release, then press: state=1, balls_left=2, gra_still=0.
- 12 hit pulses in PLAY: score=8'h12, level=1. With SCORE_DIGITS=2, 105 hits: score=8'h99, level=7.
- hit and miss in the same cycle: score +1, state stays PLAY, balls_left unchanged.
- Three misses with TIMER_FRAMES=4:
  - Each non-final miss goes to NEWBALL. A press before the 4th frame_tick is ignored; a press after it returns to PLAY.
  - The third miss goes to OVER. A 1-cycle new_record pulse follows, with hiscore = score.
  - After 4 frame ticks, state=0.
- pause_btn edge in PLAY: state=3, gra_still=1. hit/miss pulses leave score and balls_left unchanged. A second edge returns state=1.
- Second game with a lower score ending in OVER: hiscore unchanged, no new_record pulse. Assert reset mid-PLAY: all outputs return to their reset values immediately.
